// File: rtl/zbt_pkg.sv
// Shared constants and FSM encoding for the ZBT SRAM command sequencer.
package zbt_pkg;

  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_DATA_BITS = 36;
  localparam int MAX_BURST     = 16;
  localparam int LEN_BITS      = $clog2(MAX_BURST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/zbt_delay_line.sv
// Valid shift register of DEPTH stages (DEPTH >= 2) with a single data register
// that samples i_data one cycle before the valid leaves, matching ZBT data lag.
module zbt_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; the data register is reset as well
  // because it drives a pad-stage output whose idle value must be defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], i_valid};
      if (r_valid[DEPTH-2]) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data;
  assign o_busy  = |r_valid;

endmodule

// File: rtl/zbt_ctrl.sv
// ZBT SRAM command sequencer: turns burst requests into one address beat per
// clock, aligns write data two cycles behind, and tags read data after RD_LAT.
module zbt_ctrl
  import zbt_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int RD_LAT    = 4
) (
  input  logic                 fpga_clk,
  input  logic                 fpga_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 wdata_req,
  output logic [ADDR_BITS-1:0] ui_addr,
  output logic                 ui_we_n,
  output logic [DATA_BITS-1:0] ui_wdata,
  output logic                 ui_wdata_oe,
  input  logic [DATA_BITS-1:0] ui_rdata,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  state_t                r_state, w_state_nxt;
  logic [LEN_BITS-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
  logic                  r_we_n, w_we_n_nxt;
  logic                  r_wdata_req, w_wdata_req_nxt;
  logic                  w_last, w_ready, w_accept;

  logic                  w_rd_beat, w_rd_valid, w_rd_busy, w_wr_busy;
  logic                  w_rd_tag_unused;
  logic                  r_rd_valid;
  logic [DATA_BITS-1:0]  r_rd_data;

  // Ready depends only on registered state so it never loops back from req_valid.
  assign w_last   = (r_state == ST_BURST) && (r_cnt == '0);
  assign w_ready  = (r_state == ST_IDLE) || w_last;
  assign w_accept = req_valid && w_ready;

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_we_n      <= 1'b1;
      r_wdata_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_we_n      <= w_we_n_nxt;
      r_wdata_req <= w_wdata_req_nxt;
    end
  end

  // NOTE: every signal gets its default first so no path through the
  // decisions leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_we_n_nxt      = 1'b1;
    w_wdata_req_nxt = 1'b0;
    if (w_accept) begin
      w_state_nxt     = ST_BURST;
      w_cnt_nxt       = req_len;
      w_we_nxt        = req_we;
      w_addr_nxt      = req_addr;
      w_we_n_nxt      = ~req_we;
      w_wdata_req_nxt = req_we;
    end else if (r_state == ST_BURST) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_cnt_nxt       = r_cnt - LEN_BITS'(1);
        w_addr_nxt      = r_addr + ADDR_BITS'(1);
        w_we_n_nxt      = ~r_we;
        w_wdata_req_nxt = r_we;
      end
    end
  end

  zbt_delay_line #(
    .DEPTH (2),
    .WIDTH (DATA_BITS)
  ) u_wr_dly (
    .clk     (fpga_clk),
    .rst_n   (fpga_rst_n),
    .i_valid (r_wdata_req),
    .i_data  (req_wdata),
    .o_valid (ui_wdata_oe),
    .o_data  (ui_wdata),
    .o_busy  (w_wr_busy)
  );

  assign w_rd_beat = (r_state == ST_BURST) && !r_we;

  // Only the valid chain matters on the read side; the data bit is a dummy.
  zbt_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (1)
  ) u_rd_dly (
    .clk     (fpga_clk),
    .rst_n   (fpga_rst_n),
    .i_valid (w_rd_beat),
    .i_data  (1'b0),
    .o_valid (w_rd_valid),
    .o_data  (w_rd_tag_unused),
    .o_busy  (w_rd_busy)
  );

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_valid;
      if (w_rd_valid) begin
        r_rd_data <= ui_rdata;
      end
    end
  end

  assign req_ready = w_ready;
  assign wdata_req = r_wdata_req;
  assign ui_addr   = r_addr;
  assign ui_we_n   = r_we_n;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = (r_state != ST_IDLE) || w_wr_busy || w_rd_busy;

endmodule

// File: tb/tb_zbt_ctrl.sv
// Directed bench for zbt_ctrl: write/read timing, address wrap, back-to-back
// bursts, mid-burst reset and idle behaviour with hand-computed expectations.
module tb_zbt_ctrl;

  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 36;
  localparam int RD_LAT    = 4;
  localparam logic [DATA_BITS-1:0] JUNK = 36'hF_0BAD_0BAD;

  logic                 fpga_clk = 1'b0;
  logic                 fpga_rst_n = 1'b0;
  logic                 req_valid, req_ready, req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [3:0]           req_len;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 wdata_req;
  logic [ADDR_BITS-1:0] ui_addr;
  logic                 ui_we_n;
  logic [DATA_BITS-1:0] ui_wdata;
  logic                 ui_wdata_oe;
  logic [DATA_BITS-1:0] ui_rdata;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DATA_BITS-1:0] wd [4];
  logic [DATA_BITS-1:0] rw [2];
  logic [ADDR_BITS-1:0] exp_addr;
  int pulses_a, pulses_b;

  always #5 fpga_clk = ~fpga_clk;

  zbt_ctrl #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .RD_LAT    (RD_LAT)
  ) dut (
    .fpga_clk    (fpga_clk),
    .fpga_rst_n  (fpga_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .wdata_req   (wdata_req),
    .ui_addr     (ui_addr),
    .ui_we_n     (ui_we_n),
    .ui_wdata    (ui_wdata),
    .ui_wdata_oe (ui_wdata_oe),
    .ui_rdata    (ui_rdata),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req_ready"},   req_ready,   1);
    check({pfx, "_ui_addr"},     ui_addr,     0);
    check({pfx, "_ui_we_n"},     ui_we_n,     1);
    check({pfx, "_wdata_req"},   wdata_req,   0);
    check({pfx, "_ui_wdata"},    ui_wdata,    0);
    check({pfx, "_ui_wdata_oe"}, ui_wdata_oe, 0);
    check({pfx, "_rd_data"},     rd_data,     0);
    check({pfx, "_rd_valid"},    rd_valid,    0);
    check({pfx, "_busy"},        busy,        0);
  endtask

  // Presents one command for a cycle; returns in the cycle carrying beat 0.
  task automatic issue(input logic we, input logic [ADDR_BITS-1:0] addr, input logic [3:0] len);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    check("issue_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = JUNK;
    ui_rdata  = JUNK;
    wd[0] = 36'h1_1111_0000; wd[1] = 36'h2_2222_0001;
    wd[2] = 36'h3_3333_0002; wd[3] = 36'h4_4444_0003;
    rw[0] = 36'hA_0000_00A0; rw[1] = 36'hB_0000_00B1;

    #12;
    check_reset_values("por");
    #2 fpga_rst_n = 1'b1;
    step();

    // Idle for 20 cycles with no request.
    for (int c = 0; c < 20; c++) begin
      check("idle_we_n", ui_we_n, 1);
      check("idle_oe", ui_wdata_oe, 0);
      check("idle_busy", busy, 0);
      step();
    end

    // Single write to 0x1234; data presented only in the cycle after wdata_req.
    issue(1'b1, 16'h1234, 4'd0);
    check("w1_we_n", ui_we_n, 0);
    check("w1_addr", ui_addr, 16'h1234);
    check("w1_wdata_req", wdata_req, 1);
    check("w1_ready_last", req_ready, 1);
    step();
    req_wdata = 36'h9_ABCD_EF01;
    check("w1_c2_wdata_req", wdata_req, 0);
    check("w1_c2_we_n", ui_we_n, 1);
    check("w1_c2_oe", ui_wdata_oe, 0);
    check("w1_c2_busy", busy, 1);
    step();
    req_wdata = JUNK;
    check("w1_c3_oe", ui_wdata_oe, 1);
    check("w1_c3_wdata", ui_wdata, 36'h9_ABCD_EF01);
    check("w1_c3_busy", busy, 1);
    step();
    check("w1_c4_oe", ui_wdata_oe, 0);
    check("w1_c4_busy", busy, 0);

    // Single read from 0x0010; word returns in cycle 5, tagged in cycle 6.
    issue(1'b0, 16'h0010, 4'd0);
    check("r1_addr", ui_addr, 16'h0010);
    check("r1_we_n", ui_we_n, 1);
    check("r1_wdata_req", wdata_req, 0);
    pulses_a = 0;
    for (int c = 1; c <= 7; c++) begin
      ui_rdata = (c == 5) ? 36'h5_5555_5555 : JUNK;
      check("r1_rd_valid", rd_valid, (c == 6));
      check("r1_busy", busy, (c <= 5));
      if (rd_valid) pulses_a++;
      if (c == 6) check("r1_rd_data", rd_data, 36'h5_5555_5555);
      step();
    end
    check("r1_pulses", pulses_a, 1);

    // Four-beat write starting at 0xFFFE wraps to 0x0000.
    issue(1'b1, 16'hFFFE, 4'd3);
    pulses_a = 0;
    pulses_b = 0;
    for (int c = 1; c <= 7; c++) begin
      req_wdata = (c >= 2 && c <= 5) ? wd[c-2] : JUNK;
      exp_addr  = (c <= 4) ? 16'hFFFE + 16'(c - 1) : 16'h0001;
      check("wb_addr", ui_addr, exp_addr);
      check("wb_we_n", ui_we_n, (c > 4));
      check("wb_wdata_req", wdata_req, (c <= 4));
      check("wb_ready", req_ready, (c >= 4));
      check("wb_oe", ui_wdata_oe, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("wb_wdata", ui_wdata, wd[c-3]);
      if (wdata_req) pulses_a++;
      if (ui_wdata_oe) pulses_b++;
      step();
    end
    check("wb_wdata_req_pulses", pulses_a, 4);
    check("wb_oe_cycles", pulses_b, 4);

    // Four-beat write at 0x0100, then two-beat read at 0x0200 accepted on its last beat.
    issue(1'b1, 16'h0100, 4'd3);
    pulses_a = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0200;
        req_len   = 4'd1;
      end else begin
        req_valid = 1'b0;
      end
      req_wdata = (c >= 2 && c <= 5) ? wd[c-2] : JUNK;
      ui_rdata  = (c == 9 || c == 10) ? rw[c-9] : JUNK;
      exp_addr  = (c <= 4) ? 16'h0100 + 16'(c - 1) :
                  (c == 5) ? 16'h0200 : 16'h0201;
      check("bb_addr", ui_addr, exp_addr);
      check("bb_we_n", ui_we_n, (c > 4));
      check("bb_ready", req_ready, (c >= 4 && c != 5));
      check("bb_oe", ui_wdata_oe, (c >= 3 && c <= 6));
      check("bb_rd_valid", rd_valid, (c == 10 || c == 11));
      check("bb_busy", busy, (c <= 10));
      if (c == 10 || c == 11) check("bb_rd_data", rd_data, rw[c-10]);
      if (rd_valid) pulses_a++;
      step();
    end
    req_valid = 1'b0;
    check("bb_rd_pulses", pulses_a, 2);

    // Reset asserted during beat 2 of an eight-beat read.
    issue(1'b0, 16'h0300, 4'd7);
    for (int c = 1; c <= 3; c++) begin
      check("rr_addr", ui_addr, 16'h0300 + 16'(c - 1));
      check("rr_busy", busy, 1);
      if (c < 3) step();
    end
    #2 fpga_rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    step();
    step();
    #3 fpga_rst_n = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      ui_rdata = JUNK;
      check("post_rst_rd_valid", rd_valid, 0);
      check("post_rst_we_n", ui_we_n, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", req_ready, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
